// File: rtl/uart_frame_tx.sv
// UART frame transmitter: input FIFO feeding a start/data/parity/stop/gap serialiser.
// Latency: a byte accepted at edge E into an idle, empty unit is popped at E+1; txd falls at E+2.
// Backpressure: in_ready = FIFO not full (from the registered count); a push is refused when full, even if a pop occurs on the same edge.
//
// Ports:
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous reset, active-high
//   in_data     in   [DATA_BITS] byte to send, LSB first on the line
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept (not full)
//   txd         out  serial line, idle high, registered
//   busy        out  serialiser active or FIFO non-empty (registered)
//   fifo_count  out  entries currently held in the FIFO
//   frame_done  out  1-cycle pulse on the line's last cycle of the last stop bit

// Generic synchronous FIFO used as the transmitter's input queue.
// Latency: a pushed entry is visible on o_pop_dat the cycle after the push.
// Backpressure: o_push_rdy is low while full; pops on an empty FIFO are ignored.
module uart_frame_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push_vld,
    input  logic [W-1:0]  i_push_dat,
    output logic          o_push_rdy,
    input  logic          i_pop,
    output logic [W-1:0]  o_pop_dat,
    output logic          o_empty,
    output logic [AW:0]   o_count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the registered count only, so a pop on the
    // same edge never opens room for a push on a full FIFO.
    assign o_push_rdy = (r_count != FULL_CNT);
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push_vld && o_push_rdy;
    assign w_pop      = i_pop && !o_empty;
    assign o_pop_dat  = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally; the count
    // tells full from empty when the pointers are equal.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module uart_frame_tx #(
    parameter int CLK_PER_BIT = 5,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int GAP_BITS    = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

    localparam logic [TW-1:0] TMR_LOAD  = TW'(CLK_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t                 r_state;
    logic [TW-1:0]          r_tmr;
    logic [3:0]             r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_txd;
    logic                   r_busy;
    logic                   r_frame_done;

    logic                   w_fifo_rdy;
    logic                   w_fifo_empty;
    logic [DATA_BITS-1:0]   w_fifo_dat;
    logic [CW:0]            w_fifo_cnt;
    logic                   w_bit_end;
    logic                   w_stop_done;
    logic                   w_gap_done;
    logic                   w_frame_end;
    logic                   w_pop;

    uart_frame_tx_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .AW    (CW)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push_vld (in_valid),
        .i_push_dat (in_data),
        .o_push_rdy (w_fifo_rdy),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_dat),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_cnt)
    );

    // The bit timer runs CLK_PER_BIT-1 down to 0; zero marks a bit's last cycle.
    assign w_bit_end   = (r_tmr == '0);
    assign w_stop_done = (r_state == S_STOP) && w_bit_end && (r_bit == STOP_LAST);
    assign w_gap_done  = (r_state == S_GAP)  && w_bit_end && (r_bit == GAP_LAST);
    assign w_frame_end = (GAP_BITS == 0) ? w_stop_done : w_gap_done;

    // Pop either from idle or at the very last cycle of a frame, which
    // chains the next frame straight into START with no idle cycle.
    assign w_pop = !w_fifo_empty && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tmr        <= TMR_LOAD;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Every output is a flop driven from the current state, so the
            // line trails the state register by exactly one cycle.
            case (r_state)
                S_START:  r_txd <= 1'b0;
                S_DATA:   r_txd <= r_shift[0];
                S_PARITY: r_txd <= r_par;
                default:  r_txd <= 1'b1;
            endcase
            r_busy       <= (r_state != S_IDLE) || !w_fifo_empty;
            // Same one-cycle lag as txd, so the pulse lines up with the
            // final cycle of the last stop bit as seen on the line.
            r_frame_done <= w_stop_done;

            if (w_pop) begin
                r_shift <= w_fifo_dat;
                r_par   <= (^w_fifo_dat) ^ PAR_ODD;
                r_state <= S_START;
                r_tmr   <= TMR_LOAD;
                r_bit   <= '0;
            end else if (r_state != S_IDLE) begin
                if (!w_bit_end) begin
                    r_tmr <= r_tmr - 1'b1;
                end else begin
                    r_tmr <= TMR_LOAD;
                    case (r_state)
                        S_START: begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end
                        S_DATA: begin
                            r_shift <= r_shift >> 1;
                            if (r_bit == DATA_LAST) begin
                                r_bit   <= '0;
                                r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            r_state <= S_STOP;
                            r_bit   <= '0;
                        end
                        S_STOP: begin
                            if (r_bit == STOP_LAST) begin
                                r_bit   <= '0;
                                r_state <= (GAP_BITS > 0) ? S_GAP : S_IDLE;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                        S_GAP: begin
                            if (r_bit == GAP_LAST) begin
                                r_bit   <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign in_ready   = w_fifo_rdy;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign fifo_count = w_fifo_cnt;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: five differently configured instances driven
// with directed and random byte streams; the expected line waveform,
// fifo occupancy, busy and frame_done are built from the frame format.
module tb_uart_frame_tx;
    localparam int NI    = 5;
    localparam int DEPTH = 16;
    // Instance configurations: default, even parity, odd parity,
    // two stop bits plus one gap bit, and 1-clock bits with 7 data bits.
    localparam int CPB [NI] = '{5, 5, 5, 5, 1};
    localparam int DB  [NI] = '{8, 8, 8, 8, 7};
    localparam int PAR [NI] = '{0, 1, 2, 0, 0};
    localparam int STB [NI] = '{1, 1, 1, 2, 1};
    localparam int GAP [NI] = '{0, 0, 0, 1, 0};

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      in_data [NI];
    logic [NI-1:0]   in_valid;
    wire  [NI-1:0]   in_ready;
    wire  [NI-1:0]   txd;
    wire  [NI-1:0]   busy;
    wire  [NI-1:0]   frame_done;
    wire  [4:0]      fifo_count [NI];

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] cur_q[$];

    always #5 clk = ~clk;

    uart_frame_tx #(.CLK_PER_BIT(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(16)) u_dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .txd(txd[0]), .busy(busy[0]), .fifo_count(fifo_count[0]), .frame_done(frame_done[0]));
    uart_frame_tx #(.CLK_PER_BIT(5), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .txd(txd[1]), .busy(busy[1]), .fifo_count(fifo_count[1]), .frame_done(frame_done[1]));
    uart_frame_tx #(.CLK_PER_BIT(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .txd(txd[2]), .busy(busy[2]), .fifo_count(fifo_count[2]), .frame_done(frame_done[2]));
    uart_frame_tx #(.CLK_PER_BIT(5), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .GAP_BITS(1), .FIFO_DEPTH(16)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .txd(txd[3]), .busy(busy[3]), .fifo_count(fifo_count[3]), .frame_done(frame_done[3]));
    uart_frame_tx #(.CLK_PER_BIT(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(16)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data[4][6:0]), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .txd(txd[4]), .busy(busy[4]), .fifo_count(fifo_count[4]), .frame_done(frame_done[4]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int k);
        return (1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + STB[k] + GAP[k]) * CPB[k];
    endfunction

    // Line level of bit-slot idx within the frame carrying byte b.
    function automatic logic line_bit(input int k, input logic [7:0] b, input int idx);
        int ones;
        ones = 0;
        if (idx == 0) return 1'b0;
        if (idx <= DB[k]) return b[idx-1];
        if (PAR[k] != 0 && idx == DB[k] + 1) begin
            for (int i = 0; i < DB[k]; i++) ones += int'(b[i]);
            return (PAR[k] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    // Pushes cur_q into instance k on consecutive edges (honouring the
    // modelled FIFO room) and checks every cycle for ncyc edges. Edge 0 is
    // the first accept; frame f is popped at edge 1+f*FL and its line
    // waveform starts two edges after the first accept.
    task automatic run_stream(input int k, input int ncyc, input string name);
        int n;
        int fl;
        int acc;
        int pops;
        int cnt_m;
        int t;
        int stop_end;
        logic e_txd;
        logic e_fd;
        n = cur_q.size();
        fl = frame_len(k);
        stop_end = (1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + STB[k]) * CPB[k] - 1;
        acc = 0;
        cnt_m = 0;
        in_valid[k] = 1'b1;
        in_data[k] = cur_q[0];
        for (int j = 0; j < ncyc; j++) begin
            @(posedge clk);
            if (acc < n && cnt_m < DEPTH) acc++;
            pops = 0;
            if (j >= 1) pops = ((j - 1) / fl + 1 < n) ? ((j - 1) / fl + 1) : n;
            cnt_m = acc - pops;
            t = j - 2;
            e_txd = 1'b1;
            e_fd = 1'b0;
            if (t >= 0 && t < n * fl) begin
                e_txd = line_bit(k, cur_q[t / fl], (t % fl) / CPB[k]);
                e_fd = ((t % fl) == stop_end);
            end
            #1;
            chk($sformatf("%s txd k%0d c%0d", name, k, j), 32'(txd[k]), 32'(e_txd));
            chk($sformatf("%s frame_done k%0d c%0d", name, k, j), 32'(frame_done[k]), 32'(e_fd));
            chk($sformatf("%s fifo_count k%0d c%0d", name, k, j), 32'(fifo_count[k]), 32'(cnt_m));
            chk($sformatf("%s in_ready k%0d c%0d", name, k, j), 32'(in_ready[k]), 32'(cnt_m < DEPTH));
            chk($sformatf("%s busy k%0d c%0d", name, k, j), 32'(busy[k]), 32'(j >= 1 && j <= 1 + n * fl));
            in_valid[k] = (acc < n);
            if (acc < n) in_data[k] = cur_q[acc];
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic apply_reset(input string name, input int cycles);
        rst = 1'b1;
        in_valid = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s txd k%0d", name, k), 32'(txd[k]), 32'd1);
            chk($sformatf("%s busy k%0d", name, k), 32'(busy[k]), 32'd0);
            chk($sformatf("%s fifo_count k%0d", name, k), 32'(fifo_count[k]), 32'd0);
            chk($sformatf("%s in_ready k%0d", name, k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("%s frame_done k%0d", name, k), 32'(frame_done[k]), 32'd0);
        end
    endtask

    initial begin
        int k;
        int n;
        logic [7:0] mask;
        rst = 1'b1;
        in_valid = '0;
        for (int i = 0; i < NI; i++) in_data[i] = 8'h00;
        apply_reset("reset", 3);

        // Single byte on the default configuration.
        cur_q = '{8'h04};
        run_stream(0, frame_len(0) + 8, "single");

        // Boot stream: 17 bytes against a 16-entry FIFO.
        cur_q = '{8'h04, 8'h04, 8'h0c, 8'h40, 8'h01, 8'h76, 8'h01, 8'h00, 8'h00,
                  8'h44, 8'h00, 8'h40, 8'h29, 8'h06, 8'hc0, 8'hff, 8'h07};
        run_stream(0, 17 * frame_len(0) + 8, "boot");

        // Even and odd parity.
        cur_q = '{8'h07};
        run_stream(1, frame_len(1) + 8, "par_even");
        run_stream(2, frame_len(2) + 8, "par_odd");

        // Two stop bits plus a gap bit, two bytes queued.
        cur_q = '{8'ha5, 8'h3c};
        run_stream(3, 2 * frame_len(3) + 8, "stop2gap1");

        // Reset in the middle of the second frame's data bits.
        cur_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 2 + frame_len(0) + 17, "pre_rst");
        apply_reset("mid_rst", 1);
        cur_q = '{8'h5a};
        run_stream(0, frame_len(0) + 8, "post_rst");

        // One-clock bits, 7 data bits, back-to-back frames.
        cur_q = '{8'h55, 8'h2a, 8'h7f};
        run_stream(4, 3 * frame_len(4) + 8, "fast");

        // Random streams on random instances.
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 20);
            mask = 8'((1 << DB[k]) - 1);
            cur_q = {};
            for (int i = 0; i < n; i++) cur_q.push_back(8'($urandom) & mask);
            run_stream(k, n * frame_len(k) + 8, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
